resp_router_2: RTL and testbench
================================

RESP_ROUTER_2 -- requirements
Module: resp_router_2

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of outstanding-request tag entries (power of two, 2..16).
REQ-002 Parameter DATA_W, default 32, SHALL set the response payload width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_fire  input  1  SHALL be high when the upstream 2:1 arbiter's output handshake completes (out_valid & out_ready).
REQ-006 req_chosen  input  1  SHALL be the arbiter's chosen index for that handshake (0 or 1).
REQ-007 req_stall  output  1  SHALL tell the arbiter side to drop its out_ready.
REQ-008 resp_valid  input  1  SHALL be high when a response is offered.
REQ-009 resp_ready  output  1  SHALL accept the offered response.
REQ-010 resp_bits_data  input  DATA_W  SHALL be the response payload.
REQ-011 resp_bits_error  input  1  SHALL be the response error flag.
REQ-012 out_0_valid / out_1_valid  output  1 each  SHALL offer the response to requester 0 / 1.
REQ-013 out_0_ready / out_1_ready  input  1 each  SHALL be the requester accept signals.
REQ-014 out_0_bits_data / out_1_bits_data  output  DATA_W each  SHALL carry the payload.
REQ-015 out_0_bits_error / out_1_bits_error  output  1 each  SHALL carry the error flag.
REQ-016 outstanding  output  $clog2(DEPTH)+1  SHALL report the current tag-FIFO occupancy.
REQ-017 spurious  output  1  SHALL be a sticky flag for a response offered with no outstanding request.

Function
REQ-018 Each cycle with req_fire=1 and not full SHALL push req_chosen into an in-order tag FIFO.
REQ-019 req_stall SHALL equal full (occupancy == DEPTH), combinational from state only; no bypass when full.
REQ-020 req_fire=1 while full SHALL be ignored (no push, no pointer change).
REQ-021 Head tag h SHALL route the response: out_h_valid = resp_valid & !empty; the other out_valid = 0.
REQ-022 Both out_x_bits SHALL always mirror resp_bits_data / resp_bits_error (zero-latency passthrough).
REQ-023 resp_ready SHALL equal !empty & out_h_ready; the non-selected ready SHALL be ignored.
REQ-024 resp_valid & resp_ready SHALL pop the head tag at the next clock edge.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged and advance both pointers.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter width per REQ-016.
REQ-027 resp_valid=1 while empty SHALL keep resp_ready=0, both out_valid=0, and set spurious (held until reset).
REQ-028 Responses SHALL be delivered strictly in request-acceptance order.

Reset
REQ-029 reset_n low SHALL asynchronously clear pointers, occupancy, spurious and all tag entries.
REQ-030 During and after reset: req_stall=0, resp_ready=0, out_0_valid=out_1_valid=0, outstanding=0.
REQ-031 Reset mid-operation SHALL discard all outstanding tags; later responses SHALL be treated as spurious.
REQ-032 Deassertion of reset_n SHALL be usable synchronously from the first following clock edge.

Structure
REQ-033 A shared package SHALL hold DEPTH/DATA_W defaults and the requester-index type (1 bit).
REQ-034 The tag FIFO SHALL be a sub-module tag_fifo (push, pop, din, dout, full, empty, count).
REQ-035 Implementation SHALL be fully synchronous apart from the asynchronous reset; no latches.

Verification
REQ-036 Push tags 0,1,1 (req_fire in three cycles); offer three responses with data 0xA,0xB,0xC, both readies 1 -> out_0 gets 0xA, out_1 gets 0xB then 0xC; outstanding 3->0.
REQ-037 Four pushes with DEPTH=4 -> req_stall=1, outstanding=4; fifth req_fire ignored; one pop -> req_stall=0 next cycle.
REQ-038 Head tag 1, out_1_ready=0 and out_0_ready=1 for 5 cycles -> resp_ready=0, out_0_valid=0, no pop; out_1_ready=1 -> pop.
REQ-039 resp_valid=1 with outstanding=0 -> resp_ready=0, spurious=1 next cycle, stays 1 until reset_n low.
REQ-040 Occupancy 2, same-cycle push (tag 1) and pop -> outstanding stays 2; 20 random push/pop cycles wrap pointers, order preserved against a scoreboard.
REQ-041 reset_n low with outstanding=3 -> all outputs at reset values immediately (no clock needed); subsequent response sets spurious.

Source files
------------

// File: rtl/resp_router_2_pkg.sv
// Shared defaults and types for the response router and its tag FIFO.
// The requester index is one bit because the upstream arbiter is 2:1.
package resp_router_2_pkg;

    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    typedef logic req_idx_t;

endpackage

// File: rtl/resp_router_2_if.sv
// Request-tag and response handshake bundle between the arbiter side, the
// response source and the two requesters; slave is the router's view.
interface resp_router_2_if
    import resp_router_2_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              req_fire;
    req_idx_t          req_chosen;
    logic              req_stall;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_bits_data;
    logic              resp_bits_error;
    logic              out_0_valid;
    logic              out_0_ready;
    logic [DATA_W-1:0] out_0_bits_data;
    logic              out_0_bits_error;
    logic              out_1_valid;
    logic              out_1_ready;
    logic [DATA_W-1:0] out_1_bits_data;
    logic              out_1_bits_error;
    logic [CNT_W-1:0]  outstanding;
    logic              spurious;

    modport slave (
        input  req_fire, req_chosen, resp_valid, resp_bits_data, resp_bits_error,
               out_0_ready, out_1_ready,
        output req_stall, resp_ready, out_0_valid, out_0_bits_data, out_0_bits_error,
               out_1_valid, out_1_bits_data, out_1_bits_error, outstanding, spurious
    );

    modport master (
        output req_fire, req_chosen, resp_valid, resp_bits_data, resp_bits_error,
               out_0_ready, out_1_ready,
        input  req_stall, resp_ready, out_0_valid, out_0_bits_data, out_0_bits_error,
               out_1_valid, out_1_bits_data, out_1_bits_error, outstanding, spurious
    );

endinterface

// File: rtl/resp_router_2_tag_fifo.sv
// In-order FIFO of requester tags; push ignored when full, pop ignored when empty.
// Head tag is available combinationally; updates land on the next rising edge.
module tag_fifo
    import resp_router_2_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  req_idx_t                 din,
    output req_idx_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_idx_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Pointers are exactly log2(DEPTH) wide so they wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/resp_router_2.sv
// Routes each response to the requester whose request was accepted earliest.
// Zero-latency data path; stalls the arbiter when DEPTH requests are in flight.
module resp_router_2
    import resp_router_2_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    resp_router_2_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    req_idx_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_sel_rdy;
    logic              w_pop;
    logic [DATA_W-1:0] w_data;
    logic              r_spurious;

    tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (bus.req_fire),
        .pop   (w_pop),
        .din   (bus.req_chosen),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Stall derives from occupancy alone so there is no path from req_fire back to ready.
    assign bus.req_stall   = w_full;
    assign bus.outstanding = w_count;

    assign w_sel_rdy       = w_head ? bus.out_1_ready : bus.out_0_ready;
    assign bus.resp_ready  = ~w_empty & w_sel_rdy;
    assign w_pop           = bus.resp_valid & bus.resp_ready;

    assign bus.out_0_valid = bus.resp_valid & ~w_empty & (w_head == 1'b0);
    assign bus.out_1_valid = bus.resp_valid & ~w_empty & (w_head == 1'b1);

    assign w_data               = bus.resp_bits_data;
    assign bus.out_0_bits_data  = w_data;
    assign bus.out_1_bits_data  = w_data;
    assign bus.out_0_bits_error = bus.resp_bits_error;
    assign bus.out_1_bits_error = bus.resp_bits_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spurious <= 1'b0;
        end else if (bus.resp_valid && w_empty) begin
            r_spurious <= 1'b1;
        end
    end

    assign bus.spurious = r_spurious;

endmodule

// File: tb/tb_resp_router_2.sv
// Scoreboard bench for resp_router_2: directed tag/response sequences plus a
// short random push/pop phase, checked by an independent output monitor.
module tb_resp_router_2;
    import resp_router_2_pkg::*;

    typedef struct {
        logic        idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    logic model[$];

    always #5 clk = ~clk;

    resp_router_2_if #(.DEPTH(4), .DATA_W(32)) bus ();

    resp_router_2 #(.DEPTH(4), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_hs(input logic idx, input logic [31:0] d, input logic e);
        exp_t x;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL resp_route: unexpected delivery to out_%0d data %0h at %0t", idx, d, $time);
        end else begin
            x = sb.pop_front();
            if (x.idx === idx && x.data === d && x.err === e) n_pass++;
            else $display("FAIL resp_route: got out_%0d data %0h err %0b expected out_%0d data %0h err %0b at %0t",
                          idx, d, e, x.idx, x.data, x.err, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_0_valid && bus.out_0_ready) check_hs(1'b0, bus.out_0_bits_data, bus.out_0_bits_error);
            if (bus.out_1_valid && bus.out_1_ready) check_hs(1'b1, bus.out_1_bits_data, bus.out_1_bits_error);
        end
    end

    task automatic fire(input logic t);
        if (model.size() < 4) model.push_back(t);
        bus.req_fire   = 1'b1;
        bus.req_chosen = t;
        @(posedge clk); #1;
        bus.req_fire   = 1'b0;
    endtask

    task automatic resp(input logic idx, input logic [31:0] d);
        sb.push_back('{idx, d, d[0]});
        if (model.size() > 0) void'(model.pop_front());
        bus.resp_valid      = 1'b1;
        bus.resp_bits_data  = d;
        bus.resp_bits_error = d[0];
        @(posedge clk); #1;
        bus.resp_valid      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        f, p, t, acc;
        logic [31:0] d;
        reset_n             = 1'b0;
        bus.req_fire        = 1'b0;
        bus.req_chosen      = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.resp_bits_data  = '0;
        bus.resp_bits_error = 1'b0;
        bus.out_0_ready     = 1'b1;
        bus.out_1_ready     = 1'b1;
        #2;
        chk("rst_req_stall",   bus.req_stall,   0);
        chk("rst_resp_ready",  bus.resp_ready,  0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_spurious",    bus.spurious,    0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Tags 0,1,1 then responses A,B,C
        fire(1'b0); fire(1'b1); fire(1'b1);
        chk("occ_three", bus.outstanding, 3);
        resp(1'b0, 32'hA); resp(1'b1, 32'hB); resp(1'b1, 32'hC);
        chk("occ_drained", bus.outstanding, 0);

        // Fill to full, extra fire ignored
        fire(1'b0); fire(1'b1); fire(1'b0); fire(1'b1);
        chk("full_stall", bus.req_stall, 1);
        chk("full_occ", bus.outstanding, 4);
        fire(1'b1);
        chk("full_ignored_occ", bus.outstanding, 4);
        resp(1'b0, 32'h11);
        chk("stall_release", bus.req_stall, 0);
        chk("occ_after_pop", bus.outstanding, 3);

        // Head tag 1 with its requester not ready
        bus.out_1_ready     = 1'b0;
        bus.out_0_ready     = 1'b1;
        bus.resp_valid      = 1'b1;
        bus.resp_bits_data  = 32'h22;
        bus.resp_bits_error = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("blocked_resp_ready", bus.resp_ready,  0);
            chk("blocked_out0_valid", bus.out_0_valid, 0);
            chk("blocked_out1_valid", bus.out_1_valid, 1);
            @(posedge clk); #1;
        end
        chk("blocked_no_pop", bus.outstanding, 3);
        sb.push_back('{1'b1, 32'h22, 1'b0});
        void'(model.pop_front());
        bus.out_1_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        chk("unblocked_pop", bus.outstanding, 2);
        resp(1'b0, 32'h33); resp(1'b1, 32'h44);
        chk("occ_empty_again", bus.outstanding, 0);

        // Simultaneous push and pop at occupancy 2
        fire(1'b0); fire(1'b1);
        sb.push_back('{1'b0, 32'h55, 1'b1});
        void'(model.pop_front());
        model.push_back(1'b1);
        bus.req_fire = 1'b1; bus.req_chosen = 1'b1;
        bus.resp_valid = 1'b1; bus.resp_bits_data = 32'h55; bus.resp_bits_error = 1'b1;
        @(posedge clk); #1;
        bus.req_fire = 1'b0; bus.resp_valid = 1'b0;
        chk("push_pop_occ", bus.outstanding, 2);

        // Random push/pop, responses only while the model holds tags
        for (int i = 0; i < 20; i++) begin
            f   = 1'($urandom_range(0, 1));
            t   = 1'($urandom_range(0, 1));
            p   = ($urandom_range(0, 1) == 1) && (model.size() > 0);
            acc = f && (model.size() < 4);
            d   = 32'h100 + 32'(i);
            if (p) begin
                sb.push_back('{model[0], d, d[0]});
                void'(model.pop_front());
            end
            if (acc) model.push_back(t);
            bus.req_fire = f; bus.req_chosen = t;
            bus.resp_valid = p; bus.resp_bits_data = d; bus.resp_bits_error = d[0];
            @(posedge clk); #1;
        end
        bus.req_fire = 1'b0; bus.resp_valid = 1'b0;
        chk("random_occ", bus.outstanding, 32'(model.size()));
        for (int k = 0; k < 4; k++) begin
            if (model.size() > 0) resp(model[0], 32'h200 + 32'(k));
        end
        chk("random_drained", bus.outstanding, 0);

        // Response with nothing outstanding
        chk("spurious_clear", bus.spurious, 0);
        bus.resp_valid = 1'b1; bus.resp_bits_data = 32'h66;
        @(negedge clk);
        chk("spur_resp_ready", bus.resp_ready,  0);
        chk("spur_out0_valid", bus.out_0_valid, 0);
        chk("spur_out1_valid", bus.out_1_valid, 0);
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        chk("spurious_set", bus.spurious, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("spurious_sticky", bus.spurious, 1);

        // Reset clears spurious; then reset with tags in flight
        reset_n = 1'b0;
        #1;
        chk("spurious_reset", bus.spurious, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        fire(1'b0); fire(1'b1); fire(1'b1);
        chk("pre_reset_occ", bus.outstanding, 3);
        #2;
        reset_n = 1'b0;
        bus.resp_valid = 1'b1;
        #1;
        chk("async_rst_occ",    bus.outstanding, 0);
        chk("async_rst_stall",  bus.req_stall,   0);
        chk("async_rst_ready",  bus.resp_ready,  0);
        chk("async_rst_out0",   bus.out_0_valid, 0);
        chk("async_rst_out1",   bus.out_1_valid, 0);
        model.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.resp_ready,  0);
        chk("post_rst_out1",  bus.out_1_valid, 0);
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        chk("post_rst_spurious", bus.spurious, 1);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
